// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the pipeline hazard scoreboard: forwarding select
// encodings, the "operand not read" Tuse code and the in-flight writer record.
package hazard_scoreboard_pkg;

    // Forwarding select encodings for the D-stage bypass muxes
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // Tuse value meaning the operand is not read at all
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // One in-flight register writer
    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic       we;
    } wrec_t;

    // Tnew one stage later: counts down and holds at zero
    function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
        return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
    endfunction

    // Record advanced by one pipeline stage
    function automatic wrec_t rec_advance(input wrec_t rec);
        wrec_t r;
        r      = rec;
        r.tnew = tnew_dec(rec.tnew);
        return r;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy.sv
// Multiply/divide unit occupancy counter. A start loads the unit latency
// (reloading if already busy); the counter then counts down to idle.
module md_busy_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic e_md_start,
    input  logic e_md_div,
    output logic md_busy
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0] r_count;
    logic       w_count_nz;

    // Load on start, otherwise count down to zero; reset aborts any window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 4'd0;
        end else if (e_md_start) begin
            r_count <= e_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (w_count_nz) begin
            r_count <= r_count - 4'd1;
        end
    end

    // The start cycle itself already counts as busy
    always_comb begin
        w_count_nz = (r_count != 4'd0);
        md_busy    = w_count_nz | e_md_start;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: tracks register writers in E/M/W plus the HI/LO
// multiply/divide unit, and produces the D-stage stall and rs/rt forwarding
// selects combinationally from the records, the MD counter and the D inputs.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_tnew,
    input  logic       d_regwrite,
    input  logic       d_md_use,
    input  logic       e_md_start,
    input  logic       e_md_div,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       md_busy
);

    wrec_t      r_e;
    wrec_t      r_m;
    wrec_t      r_w;
    logic       w_md_busy;
    logic [2:0] w_rs_res;
    logic [2:0] w_rt_res;
    logic       w_stall;

    // Result of the nearest matching stage: {hazard, select}
    function automatic logic [2:0] stage_pick(input logic [1:0] tnew,
                                              input logic [1:0] tuse,
                                              input logic [1:0] sel);
        if (tnew > tuse)
            return {1'b1, FWD_RF};
        else if (tnew == 2'd0)
            return {1'b0, sel};
        else
            return {1'b0, FWD_RF};
    endfunction

    // A record can supply src only if it really writes a nonzero register
    function automatic logic rec_hit(input wrec_t rec, input logic [4:0] src);
        return rec.we && (rec.a3 != 5'd0) && (rec.a3 == src);
    endfunction

    // Youngest match wins (E > M > W); $0 and unread operands never match
    function automatic logic [2:0] resolve(input logic [4:0] src,
                                           input logic [1:0] tuse,
                                           input wrec_t e,
                                           input wrec_t m,
                                           input wrec_t w);
        logic [2:0] res;
        res = {1'b0, FWD_RF};
        if (src != 5'd0 && tuse != TUSE_NONE) begin
            if (rec_hit(e, src))
                res = stage_pick(e.tnew, tuse, FWD_E);
            else if (rec_hit(m, src))
                res = stage_pick(m.tnew, tuse, FWD_M);
            else if (rec_hit(w, src))
                res = stage_pick(w.tnew, tuse, FWD_W);
        end
        return res;
    endfunction

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy (
        .clk        (clk),
        .reset      (reset),
        .e_md_start (e_md_start),
        .e_md_div   (e_md_div),
        .md_busy    (w_md_busy)
    );

    // Advance writer records one stage; a stall injects a bubble into E
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e <= '0;
            r_m <= '0;
            r_w <= '0;
        end else begin
            r_w <= rec_advance(r_m);
            r_m <= rec_advance(r_e);
            r_e <= w_stall ? wrec_t'('0) : wrec_t'({d_a3, d_tnew, d_regwrite});
        end
    end

    // Hazard detection and forwarding selects; everything is quiet in reset
    always_comb begin
        w_rs_res   = resolve(d_rs, d_tuse_rs, r_e, r_m, r_w);
        w_rt_res   = resolve(d_rt, d_tuse_rt, r_e, r_m, r_w);
        w_stall    = !reset && (w_rs_res[2] || w_rt_res[2] || (d_md_use && w_md_busy));
        stall      = w_stall;
        fwd_rs_sel = reset ? FWD_RF : w_rs_res[1:0];
        fwd_rt_sel = reset ? FWD_RF : w_rt_res[1:0];
        md_busy    = w_md_busy;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a table of per-cycle vectors
// through the forwarding/stall cases, then hand sequences for the MD busy
// windows and an asynchronous reset in the middle of a divide.
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_a3;
    logic [1:0] d_tnew;
    logic       d_regwrite;
    logic       d_md_use;
    logic       e_md_start;
    logic       e_md_div;
    logic       stall;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;
    logic       md_busy;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic       we;
        logic [4:0] rs;
        logic [1:0] tu_rs;
        logic [4:0] rt;
        logic [1:0] tu_rt;
        logic       md_use;
        logic       md_start;
        logic       md_div;
        logic       x_stall;
        logic [1:0] x_rs_sel;
        logic [1:0] x_rt_sel;
        logic       x_busy;
    } vec_t;

    typedef struct packed {
        logic [15:0] tag;
        logic        stall;
        logic [1:0]  rs_sel;
        logic [1:0]  rt_sel;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[20];
    int   n_cmp  = 0;
    int   n_fail = 0;

    hazard_scoreboard #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_a3       (d_a3),
        .d_tnew     (d_tnew),
        .d_regwrite (d_regwrite),
        .d_md_use   (d_md_use),
        .e_md_start (e_md_start),
        .e_md_div   (e_md_div),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(int a3, int tnew, int we, int rs, int tu_rs,
                                int rt, int tu_rt, int use_md, int start, int div,
                                int x_stall, int x_rs, int x_rt, int x_busy);
        vec_t v;
        v.a3       = 5'(a3);
        v.tnew     = 2'(tnew);
        v.we       = 1'(we);
        v.rs       = 5'(rs);
        v.tu_rs    = 2'(tu_rs);
        v.rt       = 5'(rt);
        v.tu_rt    = 2'(tu_rt);
        v.md_use   = 1'(use_md);
        v.md_start = 1'(start);
        v.md_div   = 1'(div);
        v.x_stall  = 1'(x_stall);
        v.x_rs_sel = 2'(x_rs);
        v.x_rt_sel = 2'(x_rt);
        v.x_busy   = 1'(x_busy);
        return v;
    endfunction

    task automatic push_exp(int tag, logic s, logic [1:0] rs_sel,
                            logic [1:0] rt_sel, logic busy);
        exp_t e;
        e.tag    = 16'(tag);
        e.stall  = s;
        e.rs_sel = rs_sel;
        e.rt_sel = rt_sel;
        e.busy   = busy;
        exp_q.push_back(e);
    endtask

    task automatic cmp(string name, int tag, logic [3:0] act, logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s tag=%0d: got %0d, expected %0d", name, tag, act, req);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = exp_q.pop_front();
        cmp("stall",      int'(e.tag), {3'b0, stall},   {3'b0, e.stall});
        cmp("fwd_rs_sel", int'(e.tag), {2'b0, fwd_rs_sel}, {2'b0, e.rs_sel});
        cmp("fwd_rt_sel", int'(e.tag), {2'b0, fwd_rt_sel}, {2'b0, e.rt_sel});
        cmp("md_busy",    int'(e.tag), {3'b0, md_busy}, {3'b0, e.busy});
    endtask

    task automatic drive_vec(vec_t v);
        d_a3       = v.a3;
        d_tnew     = v.tnew;
        d_regwrite = v.we;
        d_rs       = v.rs;
        d_tuse_rs  = v.tu_rs;
        d_rt       = v.rt;
        d_tuse_rt  = v.tu_rt;
        d_md_use   = v.md_use;
        e_md_start = v.md_start;
        e_md_div   = v.md_div;
    endtask

    // One cycle: drive (just after posedge), check at negedge, advance
    task automatic step(vec_t v, int tag);
        drive_vec(v);
        push_exp(tag, v.x_stall, v.x_rs_sel, v.x_rt_sel, v.x_busy);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // a3 tn we | rs tu | rt tu | use st div | stall rs rt busy
        vecs[0]  = mk( 8, 2, 1,   0, 3,   0, 3,  0, 0, 0,  0, 0, 0, 0);
        vecs[1]  = mk( 0, 0, 0,   8, 0,   0, 3,  0, 0, 0,  1, 0, 0, 0);
        vecs[2]  = mk( 0, 0, 0,   8, 0,   0, 3,  0, 0, 0,  1, 0, 0, 0);
        vecs[3]  = mk( 9, 1, 1,   8, 0,   0, 3,  0, 0, 0,  0, 3, 0, 0);
        vecs[4]  = mk( 9, 0, 1,   0, 3,   9, 1,  0, 0, 0,  0, 0, 0, 0);
        vecs[5]  = mk(31, 0, 1,   9, 0,   9, 1,  0, 0, 0,  0, 1, 1, 0);
        vecs[6]  = mk( 0, 0, 0,   9, 0,  31, 3,  0, 0, 0,  0, 2, 0, 0);
        vecs[7]  = mk( 0, 2, 1,  31, 2,   9, 0,  0, 0, 0,  0, 2, 3, 0);
        vecs[8]  = mk( 0, 0, 0,   0, 0,  31, 0,  0, 0, 0,  0, 0, 3, 0);
        vecs[9]  = mk( 5, 2, 1,   0, 0,   0, 0,  0, 0, 0,  0, 0, 0, 0);
        vecs[10] = mk( 0, 0, 0,   5, 3,   5, 2,  0, 0, 0,  0, 0, 0, 0);
        vecs[11] = mk( 0, 0, 0,   5, 0,   5, 1,  0, 0, 0,  1, 0, 0, 0);
        vecs[12] = mk( 0, 0, 0,   5, 0,   5, 1,  0, 0, 0,  0, 3, 3, 0);
        vecs[13] = mk( 0, 0, 0,   0, 3,   0, 3,  0, 1, 0,  0, 0, 0, 1);
        vecs[14] = mk( 0, 0, 0,   5, 0,   0, 3,  1, 0, 0,  1, 0, 0, 1);
        vecs[15] = mk( 0, 0, 0,   0, 3,   0, 3,  0, 0, 0,  0, 0, 0, 1);
        vecs[16] = mk( 0, 0, 0,   0, 3,   0, 3,  0, 0, 0,  0, 0, 0, 1);
        vecs[17] = mk( 0, 0, 0,   0, 3,   0, 3,  0, 0, 0,  0, 0, 0, 1);
        vecs[18] = mk( 0, 0, 0,   0, 3,   0, 3,  0, 0, 0,  0, 0, 0, 1);
        vecs[19] = mk( 0, 0, 0,   0, 3,   0, 3,  0, 0, 0,  0, 0, 0, 0);

        // Reset state, including md_busy following e_md_start during reset
        reset = 1'b1;
        drive_vec(mk(0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        #2;
        push_exp(100, 1'b0, 2'd0, 2'd0, 1'b0);
        check_out();
        d_md_use   = 1'b1;
        e_md_start = 1'b1;
        #1;
        push_exp(101, 1'b0, 2'd0, 2'd0, 1'b1);
        check_out();
        d_md_use   = 1'b0;
        e_md_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) step(vecs[i], i);

        // Divide window: start cycle plus 10 busy cycles stall a MD user
        for (int k = 0; k < 12; k++)
            step(mk(0, 0, 0, 0, 3, 0, 3, 1, (k == 0) ? 1 : 0, 1,
                    (k <= 10) ? 1 : 0, 0, 0, (k <= 10) ? 1 : 0), 200 + k);

        // Multiply window: start cycle plus 5 busy cycles
        for (int k = 0; k < 7; k++)
            step(mk(0, 0, 0, 0, 3, 0, 3, 1, (k == 0) ? 1 : 0, 0,
                    (k <= 5) ? 1 : 0, 0, 0, (k <= 5) ? 1 : 0), 300 + k);

        // Start while busy reloads: mult start, then divide start two cycles in
        step(mk(0, 0, 0, 0, 3, 0, 3, 0, 1, 0, 0, 0, 0, 1), 350);
        step(mk(0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 1), 351);
        for (int k = 0; k < 12; k++)
            step(mk(0, 0, 0, 0, 3, 0, 3, 1, (k == 0) ? 1 : 0, 1,
                    (k <= 10) ? 1 : 0, 0, 0, (k <= 10) ? 1 : 0), 360 + k);

        // Reset during the 4th busy cycle of a divide
        step(mk(7, 2, 1, 0, 3, 0, 3, 0, 1, 1, 0, 0, 0, 1), 400);
        step(mk(0, 0, 0, 0, 3, 0, 3, 1, 0, 0, 1, 0, 0, 1), 401);
        step(mk(0, 0, 0, 0, 3, 0, 3, 1, 0, 0, 1, 0, 0, 1), 402);
        drive_vec(mk(0, 0, 0, 7, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0));
        push_exp(403, 1'b1, 2'd3, 2'd0, 1'b1);
        @(negedge clk);
        check_out();
        #1;
        reset = 1'b1;
        #1;
        push_exp(404, 1'b0, 2'd0, 2'd0, 1'b0);
        check_out();
        e_md_start = 1'b1;
        #1;
        push_exp(405, 1'b0, 2'd0, 2'd0, 1'b1);
        check_out();
        drive_vec(mk(0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        // First D instruction after release reads the cleared $7 writer
        step(mk(0, 0, 0, 7, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0), 406);
        step(mk(0, 0, 0, 7, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0), 407);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
